// File: rtl/sdram_pkg.sv
// sdram_pkg: SDRAM command constants, arbiter state encodings and shared
// widths used by the command-bus arbiter and its watchdog.
package sdram_pkg;

  // Default SDRAM row/column address width.
  localparam int DEF_ADDR_W = 13;

  // Width of the grant watchdog counter; BUSY_MAX_CLK must fit in it.
  localparam int BUSY_CNT_W = 10;

  // SDRAM commands, encoded as {cs_n, ras_n, cas_n, we_n}.
  localparam logic [3:0] NOP      = 4'b0111;
  localparam logic [3:0] ACTIVE   = 4'b0011;
  localparam logic [3:0] READ     = 4'b0101;
  localparam logic [3:0] WRITE    = 4'b0100;
  localparam logic [3:0] B_STOP   = 4'b0110;
  localparam logic [3:0] P_CHARGE = 4'b0010;
  localparam logic [3:0] AREF     = 4'b0001;

  // Arbiter states: power-up init, idle arbitration, and one grant state
  // per sequencer.
  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_ARBIT = 3'd1,
    ST_AREF  = 3'd2,
    ST_WRITE = 3'd3,
    ST_READ  = 3'd4
  } arb_state_e;

  // Which of write/read owned the bus most recently (round-robin build).
  typedef enum logic {
    LG_READ  = 1'b0,
    LG_WRITE = 1'b1
  } last_grant_e;

  // True in any state where a sequencer owns the command bus.
  function automatic logic is_grant_state(input arb_state_e s);
    return (s == ST_AREF) || (s == ST_WRITE) || (s == ST_READ);
  endfunction

endpackage

// File: rtl/sdram_arb_wdog.sv
// sdram_arb_wdog: grant watchdog. Counts cycles a sequencer has held the
// bus and flags expiry when the count reaches BUSY_MAX_CLK, so a sequencer
// that never signals its end cannot lock the SDRAM forever.
module sdram_arb_wdog
  import sdram_pkg::*;
#(
  parameter int BUSY_MAX_CLK = 1023
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic in_grant,
  output logic expire
);

  localparam logic [BUSY_CNT_W-1:0] BUSY_MAX = BUSY_CNT_W'(BUSY_MAX_CLK);

  logic [BUSY_CNT_W-1:0] busy_cnt_q;
  logic [BUSY_CNT_W-1:0] busy_cnt_d;

  // The first grant cycle sees a count of 0, so expiry lands in the grant
  // cycle that follows BUSY_MAX_CLK completed ones.
  assign expire = in_grant && (busy_cnt_q == BUSY_MAX);

  // Next count: clear outside grants and on expiry, otherwise advance.
  always_comb begin
    busy_cnt_d = '0;
    if (in_grant && !expire) begin
      busy_cnt_d = busy_cnt_q + BUSY_CNT_W'(1);
    end
  end

  // Busy counter register.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      busy_cnt_q <= '0;
    end else begin
      busy_cnt_q <= busy_cnt_d;
    end
  end

endmodule

// File: rtl/sdram_arbit.sv
// sdram_arbit: SDRAM command-bus arbiter. Holds off traffic until the init
// sequencer finishes, then grants the bus to one of refresh / write / read
// at a time (refresh first) and muxes the owner's command, bank and address
// onto the pins. Every hand-over passes through ST_ARBIT, which drives NOP,
// so there is always a NOP cycle between owners.
// Build option: define SDRAM_ARB_RR_EN to alternate write/read when both
// request together; otherwise write always wins that tie.
module sdram_arbit
  import sdram_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int BUSY_MAX_CLK = 1023
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  // init sequencer
  input  logic              init_end,
  input  logic [3:0]        init_cmd,
  input  logic [1:0]        init_ba,
  input  logic [ADDR_W-1:0] init_addr,
  // refresh sequencer
  input  logic              aref_req,
  input  logic              aref_end,
  input  logic [3:0]        aref_cmd,
  input  logic [1:0]        aref_ba,
  input  logic [ADDR_W-1:0] aref_addr,
  // write sequencer
  input  logic              wr_req,
  input  logic              wr_end,
  input  logic [3:0]        wr_cmd,
  input  logic [1:0]        wr_ba,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              wr_sdram_en,
  input  logic [15:0]       wr_sdram_data,
  // read sequencer
  input  logic              rd_req,
  input  logic              rd_end,
  input  logic [3:0]        rd_cmd,
  input  logic [1:0]        rd_ba,
  input  logic [ADDR_W-1:0] rd_addr,
  // grants
  output logic              aref_en,
  output logic              wr_en,
  output logic              rd_en,
  // SDRAM pins
  output logic              sdram_cke,
  output logic              sdram_cs_n,
  output logic              sdram_ras_n,
  output logic              sdram_cas_n,
  output logic              sdram_we_n,
  output logic [1:0]        sdram_ba,
  output logic [ADDR_W-1:0] sdram_addr,
  output logic              sdram_dq_oe,
  output logic [15:0]       sdram_dq_out,
  // watchdog
  output logic              arb_timeout
);

  arb_state_e        state_q;
  arb_state_e        state_d;
  logic              cke_q;
  logic              cke_d;
  logic              expire;
  logic              wr_wins_tie;
  logic [3:0]        cmd_mux;
  logic [1:0]        ba_mux;
  logic [ADDR_W-1:0] addr_mux;

`ifdef SDRAM_ARB_RR_EN
  last_grant_e last_grant_q;
  last_grant_e last_grant_d;

  // Alternate on a write/read tie: whoever did not go last goes now.
  assign wr_wins_tie = (last_grant_q == LG_READ);
`else
  assign wr_wins_tie = 1'b1;
`endif

  // Watchdog revokes a grant that has been held too long.
  sdram_arb_wdog #(
    .BUSY_MAX_CLK (BUSY_MAX_CLK)
  ) u_wdog (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .in_grant (is_grant_state(state_q)),
    .expire   (expire)
  );

  // Next-state logic: init gate, fixed-priority pick, release on end/expiry.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT: begin
        if (init_end) state_d = ST_ARBIT;
      end
      ST_ARBIT: begin
        if (aref_req) begin
          state_d = ST_AREF;
        end else if (wr_req && rd_req) begin
          state_d = wr_wins_tie ? ST_WRITE : ST_READ;
        end else if (wr_req) begin
          state_d = ST_WRITE;
        end else if (rd_req) begin
          state_d = ST_READ;
        end
      end
      ST_AREF: begin
        if (aref_end || expire) state_d = ST_ARBIT;
      end
      ST_WRITE: begin
        if (wr_end || expire) state_d = ST_ARBIT;
      end
      ST_READ: begin
        if (rd_end || expire) state_d = ST_ARBIT;
      end
      default: state_d = ST_INIT;
    endcase
  end

  // Clock enable stays low for the cycle(s) following a reset edge.
  always_comb begin
    cke_d = 1'b1;
  end

  // State and clock-enable registers.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= ST_INIT;
      cke_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cke_q   <= cke_d;
    end
  end

`ifdef SDRAM_ARB_RR_EN
  // Remember the last data-path owner whenever a write or read is granted.
  always_comb begin
    last_grant_d = last_grant_q;
    if (state_q == ST_ARBIT) begin
      if (state_d == ST_WRITE) last_grant_d = LG_WRITE;
      if (state_d == ST_READ)  last_grant_d = LG_READ;
    end
  end

  // Last-grant register; read counts as last so write wins the first tie.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      last_grant_q <= LG_READ;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`endif

  // Pin mux: owner's bus in grant states, init bus in ST_INIT, idle pattern
  // otherwise and whenever the clock enable is still low out of reset.
  always_comb begin
    cmd_mux  = NOP;
    ba_mux   = 2'b11;
    addr_mux = '1;
    if (cke_q) begin
      case (state_q)
        ST_INIT: begin
          cmd_mux  = init_cmd;
          ba_mux   = init_ba;
          addr_mux = init_addr;
        end
        ST_AREF: begin
          cmd_mux  = aref_cmd;
          ba_mux   = aref_ba;
          addr_mux = aref_addr;
        end
        ST_WRITE: begin
          cmd_mux  = wr_cmd;
          ba_mux   = wr_ba;
          addr_mux = wr_addr;
        end
        ST_READ: begin
          cmd_mux  = rd_cmd;
          ba_mux   = rd_ba;
          addr_mux = rd_addr;
        end
        default: begin
          cmd_mux  = NOP;
          ba_mux   = 2'b11;
          addr_mux = '1;
        end
      endcase
    end
  end

  assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd_mux;
  assign sdram_ba     = ba_mux;
  assign sdram_addr   = addr_mux;
  assign sdram_cke    = cke_q;

  assign aref_en      = (state_q == ST_AREF);
  assign wr_en        = (state_q == ST_WRITE);
  assign rd_en        = (state_q == ST_READ);

  // DQ is only driven while the write sequencer owns the bus and asks for it.
  assign sdram_dq_oe  = (state_q == ST_WRITE) && wr_sdram_en;
  assign sdram_dq_out = sdram_dq_oe ? wr_sdram_data : 16'h0000;

  assign arb_timeout  = expire;

endmodule
